// File: rtl/icache_refill_axi_pkg.sv
// -----------------------------------------------------------------------------
// icache_refill_axi_pkg
// Shared constants and types for the instruction-cache refill bridge:
//   LINE_BYTES / LINE_WORDS  cache line geometry (LINE_WORDS is a power of two)
//   OFF                      byte-offset bits inside a line
//   CNT_W                    width of the beat / word index
//   BURST_INCR, SIZE_4B      AXI4 encodings used on the AR channel
//   AR_LEN                   AXI beat count minus one for a full line
//   state_t                  refill FSM states
//   line_align()             strips the in-line offset from a fetch address
// -----------------------------------------------------------------------------
package icache_refill_axi_pkg;

    localparam int LINE_BYTES = 16;
    localparam int LINE_WORDS = LINE_BYTES / 4;
    localparam int OFF        = $clog2(LINE_BYTES);
    localparam int CNT_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [7:0] AR_LEN     = 8'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:OFF], {OFF{1'b0}}};
    endfunction

endpackage

// File: rtl/icache_refill_axi_if.sv
// -----------------------------------------------------------------------------
// icache_refill_axi_if
// AXI4 read-only subset (AR and R channels) used by the refill bridge.
//   master: the bridge   - drives arid/araddr/arlen/arsize/arburst/arvalid, rready
//   slave : the fabric   - drives arready, rid/rdata/rresp/rlast/rvalid
// -----------------------------------------------------------------------------
interface icache_refill_axi_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/icache_line_buffer.sv
// -----------------------------------------------------------------------------
// icache_line_buffer
// Word-addressed line assembly register. Each write replaces one 32-bit word;
// words not written keep their previous value (no clear between refills).
//   clk, rst   clock, synchronous active-high reset
//   we         write enable for this cycle
//   idx        word index within the line
//   wdata      word to store
//   line_data  flat line, word i in bits [32*i +: 32]
// -----------------------------------------------------------------------------
module icache_line_buffer
    import icache_refill_axi_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [CNT_W-1:0]          idx,
    input  logic [31:0]               wdata,
    output logic [32*LINE_WORDS-1:0]  line_data
);

    // NOTE: this storage is reset on purpose: line_data is a visible output
    // whose reset value is defined as zero, so it cannot be left unknown.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_data <= '0;
        end else begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                if (we && idx == CNT_W'(i)) begin
                    line_data[32*i +: 32] <= wdata;
                end
            end
        end
    end

endmodule

// File: rtl/icache_refill_axi.sv
// -----------------------------------------------------------------------------
// icache_refill_axi
// Services instruction-cache line refills with a single AXI4 INCR read burst.
// One burst outstanding at a time; the cache may withdraw its request at any
// point, in which case the burst is drained and its data discarded.
//   clk, rst    clock, synchronous active-high reset (shared with the fabric)
//   req_valid   level-held refill request from the cache miss path
//   req_addr    fetch address of the missing instruction
//   req_ready   one-cycle pulse: line_data / line_err valid for the request
//   line_data   assembled line, word i in bits [32*i +: 32]
//   line_err    some beat of the burst returned a SLVERR/DECERR
//   axi         AXI4 AR/R master port
// -----------------------------------------------------------------------------
module icache_refill_axi
    import icache_refill_axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    input  logic [31:0]               req_addr,
    output logic                      req_ready,
    output logic [32*LINE_WORDS-1:0]  line_data,
    output logic                      line_err,
    icache_refill_axi_if.master       axi
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cancel;
    logic             beat;

    // Fixed burst shape: one full line of 4-byte beats.
    assign axi.arid    = AXI_ID;
    assign axi.arlen   = AR_LEN;
    assign axi.arsize  = SIZE_4B;
    assign axi.arburst = BURST_INCR;

    // rready is only ever high in R, so this is exactly "accepted beat in R".
    assign beat = axi.rvalid & axi.rready;

    // Decoded from registered state and the cache's own request only; nothing
    // from the AXI side reaches req_ready combinationally.
    assign req_ready = (state == DONE) & req_valid;

    // Only one burst is ever outstanding, and only rresp[1] marks an error.
    logic unused_inputs;
    assign unused_inputs = ^{axi.rid, axi.rresp[0], req_addr[OFF-1:0]};

    icache_line_buffer u_line_buffer (
        .clk       (clk),
        .rst       (rst),
        .we        (beat),
        .idx       (cnt),
        .wdata     (axi.rdata),
        .line_data (line_data)
    );

    // NOTE: all state in this block uses non-blocking assignments so every
    // branch reads the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b0;
            axi.araddr  <= '0;
            line_err    <= 1'b0;
            cnt         <= '0;
            cancel      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt      <= '0;
                    line_err <= 1'b0;
                    cancel   <= 1'b0;
                    if (req_valid) begin
                        axi.araddr  <= line_align(req_addr);
                        axi.arvalid <= 1'b1;
                        state       <= AR;
                    end
                end

                AR: begin
                    // arvalid stays up until accepted even when cancelled;
                    // the cancel flag only suppresses the final handover.
                    if (!req_valid) cancel <= 1'b1;
                    if (axi.arready) begin
                        axi.arvalid <= 1'b0;
                        axi.rready  <= 1'b1;
                        state       <= R;
                    end
                end

                R: begin
                    if (!req_valid) cancel <= 1'b1;
                    if (beat) begin
                        cnt      <= cnt + 1'b1;
                        line_err <= line_err | axi.rresp[1];
                        // rlast alone ends the burst; beat count is not policed.
                        if (axi.rlast) begin
                            axi.rready <= 1'b0;
                            // A drop on the last beat itself also cancels.
                            state      <= (cancel || !req_valid) ? IDLE : DONE;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/icache_refill_axi.md
# icache_refill_axi

AXI4 read-burst bridge that services instruction-cache line refills. Sits directly downstream of the instruction-cache controller's miss path: it accepts the controller's level-held refill request, issues one INCR burst for the missing line, assembles the returned beats into a line buffer and hands back the full line with a single-cycle ready pulse. It supports one outstanding burst and tolerates the controller withdrawing its request mid-refill, for example on a pipeline stall or flush.

## Interface
- LINE_WORDS, 4: 32-bit words per cache line; power of two.
- AXI_ID, 4'd0: fixed ARID value.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  refill request; held high by the cache while it waits; may drop at any time (cancel).
- req_addr  in  32  fetch address of the missing instruction; low log2(LINE_WORDS*4) bits ignored.
- req_ready  out  1  one-cycle pulse: line_data and line_err are valid for the request.
- line_data  out  32*LINE_WORDS  assembled line; word i in bits [32*i +: 32].
- line_err  out  1  high if any beat of the burst returned rresp[1]=1.
- arid  out  4  = AXI_ID.
- araddr  out  32  line-aligned address.
- arlen  out  8  = LINE_WORDS-1.
- arsize  out  3  = 3'b010.
- arburst  out  2  = 2'b01 (INCR).
- arvalid  out  1  / arready  in  1  AXI address handshake.
- rid  in  4  ignored; only one burst is ever outstanding.
- rdata  in  32  read data.
- rresp  in  2  read response.
- rlast  in  1  last beat.
- rvalid  in  1  / rready  out  1  AXI data handshake.

## Operation
- States: IDLE, AR, R, DONE.
- IDLE
  - If req_valid: latch araddr = {req_addr[31:OFF], OFF'b0}, where OFF = log2(LINE_WORDS*4).
  - Clear the beat counter, line_err and the cancel flag; go to AR.
- AR
  - arvalid=1 and address held stable.
  - On arready, go to R. arvalid is never withdrawn before arready, even if cancelled.
- R
  - rready=1 throughout.
  - Each rvalid beat writes rdata into line word cnt; cnt increments mod LINE_WORDS.
  - line_err |= rresp[1] on each beat.
  - On the beat with rvalid&rlast: go to DONE if not cancelled, else go to IDLE.
  - Only rlast ends the burst; the beat count is not checked.
- DONE
  - req_ready = req_valid; go to IDLE unconditionally.
- Cancel flag
  - Set in any AR or R cycle with req_valid=0; sticky until IDLE.
  - A cancelled burst is drained and discarded; req_ready is not asserted for it.
- New requests are accepted only in IDLE. A request re-raised during a drain waits for IDLE and starts a fresh burst.
- line_data holds its value outside R and may only be read in the req_ready cycle.

## Timing
- Reset values: state IDLE; arvalid=0, rready=0, req_ready=0, araddr=0, line_data=0, line_err=0, cnt=0. Reset mid-burst abandons the burst; the interconnect shares rst.
- Best case (arready and rvalid with no wait states): req_valid seen in IDLE at cycle 0; arvalid in cycle 1; beats in cycles 2..LINE_WORDS+1; req_ready in cycle LINE_WORDS+2.
- All outputs are registered or decoded from state only; no combinational path from AXI inputs to req_ready.
- The cache drops req_valid in the cycle after req_ready. Since this block is in IDLE by then, no spurious second burst is issued.
- The DONE cycle holds line_data stable so the cache can write it into the selected way and the return register in that same cycle.

## Structure
- Shared package: LINE_WORDS (derived from the cache line size constant), OFF, AXI burst/size encodings (INCR, SIZE_4B), and the state enum.
- One natural sub-module: icache_line_buffer, which takes a word index, write enable and data and exposes the flat line vector with clear-free hold.

## Test plan
- Basic refill: req_addr=0x1C00_0014, zero wait states, beats 0xA0..0xA3 -> araddr=0x1C00_0010, arlen=3; req_ready in cycle 6; line_data={A3,A2,A1,A0}; line_err=0.
- Backpressure: arready delayed 3 cycles and rvalid gapped every other cycle -> arvalid and araddr stable until handshake; correct line; req_ready exactly once.
- Cancel in R: req_valid dropped after beat 1 -> remaining beats accepted with rready=1; no req_ready; next request in IDLE issues a new AR.
- Cancel in AR, then re-request at 0x1C00_0040 before arready -> first burst drained and discarded; second AR carries 0x1C00_0040 after drain; single req_ready for the second line.
- Error response: beat 2 rresp=2'b10 -> line_err=1 with req_ready; next clean refill -> line_err=0.
- Reset asserted during beat 2 -> next cycle state IDLE and all outputs at reset values; a subsequent request completes normally.
